serial_add_ctrl: RTL

Bit-serial addition controller that time-shares a single combinational 1-bit full adder (ports C_in, a, b, sum, C_out) to add two WIDTH-bit operands. It accepts an operand pair over a valid/ready handshake and feeds the full adder one bit per clock, LSB first. It carries the running carry in a register and assembles the result in a shift register. It sits between an operand source and a result consumer, with the full adder instantiated outside it and wired to its fa_* ports.

---
 rtl/serial_add_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller. Drives an external 1-bit full adder one operand
// bit per clock, LSB first, keeping the running carry in a register and
// shifting sum bits into the result from the MSB end.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  // One extra counter bit keeps WIDTH=1 legal ($clog2(1) is 0).
  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_a_q, shift_a_d;
  logic [WIDTH-1:0] shift_b_q, shift_b_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             overflow_q, overflow_d;

  logic             running;

  assign running = (state_q == StRun);

  // Next-state logic: load on accept, shift one bit per RUN cycle, wait for consumer.
  always_comb begin
    state_d    = state_q;
    shift_a_d  = shift_a_q;
    shift_b_d  = shift_b_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;
    case (state_q)
      StIdle: begin
        if (start_valid) begin
          shift_a_d  = op_a;
          shift_b_d  = op_b;
          carry_d    = cin;
          cnt_d      = '0;
          result_d   = '0;
          cout_d     = 1'b0;
          overflow_d = 1'b0;
          state_d    = StRun;
        end
      end
      StRun: begin
        shift_a_d = shift_a_q >> 1;
        shift_b_d = shift_b_q >> 1;
        // Shift-then-insert avoids a [WIDTH-1:1] slice that is empty at WIDTH=1.
        result_d            = result_q >> 1;
        result_d[WIDTH-1]   = fa_sum;
        carry_d             = fa_cout;
        cnt_d               = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          cout_d     = fa_cout;
          // carry_q is the carry into the MSB on this last cycle.
          overflow_d = carry_q ^ fa_cout;
          state_d    = StDone;
        end
      end
      StDone: begin
        // No accept here: the next operand pair waits for a real IDLE cycle.
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      shift_a_q  <= '0;
      shift_b_q  <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_a_q  <= shift_a_d;
      shift_b_q  <= shift_b_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
    end
  end

  // Full-adder operands are gated so the adder sees zeros outside RUN.
  always_comb begin
    fa_a   = running & shift_a_q[0];
    fa_b   = running & shift_b_q[0];
    fa_cin = running & carry_q;
  end

  assign start_ready = (state_q == StIdle);
  assign res_valid   = (state_q == StDone);
  assign result      = result_q;
  assign cout        = cout_q;
  assign overflow    = overflow_q;

endmodule
